// File: rtl/resolve_bht.sv
// -----------------------------------------------------------------------------
// resolve_bht -- branch history table of 2-bit saturating counters, updated
// from branch resolutions through a small update queue.
//
// A resolve from the branch unit is accepted only for conditional branches
// (valid=1 and cf_type==Branch). An accepted resolve is queued as
// {index, is_taken} and applied one per cycle while the table is in RUN.
// After reset, and on every flush, a sweep rewrites every counter to
// weakly-not-taken (2'b01), one entry per cycle in ascending index order.
// No predictions are given during the sweep. Queued updates survive a flush
// but not a reset.
//
// Optional build macro: RESOLVE_BHT_BYPASS_EN
//   When defined, a lookup that hits the entry being written in the same
//   cycle returns the new counter value instead of the stored one.
//
// Parameters
//   NR_ENTRIES  number of 2-bit counters (power of two, >= 4)
//   FIFO_DEPTH  update queue depth       (power of two, >= 2)
//
// Ports
//   clk_i              in   clock; all state changes on the rising edge
//   rst_ni             in   asynchronous active-low reset
//   flush_bp_i         in   restart the clearing sweep at index 0
//   resolved_branch_i  in   branch resolution (valid, pc, is_taken, cf_type)
//   vpc_i              in   fetch PC to predict
//   bht_valid_o        out  prediction valid (table in RUN)
//   bht_taken_o        out  predicted taken, combinational from vpc_i
//   busy_o             out  clearing sweep in progress
//   drop_cnt_o         out  updates lost to a full queue, saturating at 8'hFF
//
// The riscv and ariane_pkg packages below carry the minimal subset of the
// host core's definitions this block depends on.
// -----------------------------------------------------------------------------

package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target_address;
        logic                   is_mispredict;
        logic                   is_taken;
        cf_t                    cf_type;
    } bp_resolve_t;
endpackage

module resolve_bht #(
    parameter int unsigned NR_ENTRIES = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_bp_i,
    input  ariane_pkg::bp_resolve_t  resolved_branch_i,
    input  logic [riscv::VLEN-1:0]   vpc_i,
    output logic                     bht_valid_o,
    output logic                     bht_taken_o,
    output logic                     busy_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    // Saturating 2-bit counter step: taken counts up to 2'b11, not-taken
    // counts down to 2'b00.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == 2'b11) begin
                res = 2'b11;
            end else begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr == 2'b00) begin
                res = 2'b00;
            end else begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

    // FSM and sweep state
    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] sweep_idx_r;
    logic [IDX_W-1:0] sweep_idx_s;

    // Update queue
    upd_t             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fill_r;
    upd_t             head_s;
    upd_t             push_data_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             push_ok_s;
    logic             pop_s;
    logic             drop_s;

    logic [7:0]       drop_cnt_r;

    // Counter table and its single write port
    logic [1:0]       table_r [NR_ENTRIES];
    logic             tbl_we_s;
    logic [IDX_W-1:0] tbl_widx_s;
    logic [1:0]       tbl_wdata_s;

    // Lookup
    logic [IDX_W-1:0] lkp_idx_s;
    logic [1:0]       lkp_ctr_s;

    // Fields of the resolve and PC bits that play no part in indexing.
    logic             unused_s;
    assign unused_s = ^{resolved_branch_i, vpc_i};

    // Queue status and handshake. The pop is withheld in CLEAR and whenever a
    // flush is requested, so the flush owns the table port that cycle and the
    // head entry stays queued. A push into a full queue still succeeds when
    // the head leaves in the same cycle.
    always_comb begin
        push_s       = resolved_branch_i.valid &&
                       (resolved_branch_i.cf_type == ariane_pkg::Branch);
        push_data_s  = {resolved_branch_i.pc[IDX_W:1], resolved_branch_i.is_taken};
        fifo_empty_s = (fill_r == {CNT_W{1'b0}});
        fifo_full_s  = (fill_r == CNT_W'(FIFO_DEPTH));
        head_s       = fifo_mem_r[rd_ptr_r];
        pop_s        = (state_r == RUN) && !flush_bp_i && !fifo_empty_s;
        push_ok_s    = push_s && (!fifo_full_s || pop_s);
        drop_s       = push_s && fifo_full_s && !pop_s;
    end

    // Table write port arbitration: the sweep owns it in CLEAR, the queue
    // head owns it in RUN when it pops.
    always_comb begin
        tbl_we_s    = 1'b0;
        tbl_widx_s  = {IDX_W{1'b0}};
        tbl_wdata_s = 2'b00;
        if (state_r == CLEAR) begin
            tbl_we_s    = 1'b1;
            tbl_widx_s  = sweep_idx_r;
            tbl_wdata_s = 2'b01;
        end else if (pop_s) begin
            tbl_we_s    = 1'b1;
            tbl_widx_s  = head_s.idx;
            tbl_wdata_s = sat_update(table_r[head_s.idx], head_s.taken);
        end else begin
            tbl_we_s    = 1'b0;
        end
    end

    // FSM next-state and sweep index. A flush in either state restarts the
    // sweep at index 0 on the next edge.
    always_comb begin
        state_s     = state_r;
        sweep_idx_s = sweep_idx_r;
        case (state_r)
            CLEAR: begin
                if (flush_bp_i) begin
                    state_s     = CLEAR;
                    sweep_idx_s = {IDX_W{1'b0}};
                end else if (sweep_idx_r == IDX_W'(NR_ENTRIES - 1)) begin
                    state_s     = RUN;
                    sweep_idx_s = {IDX_W{1'b0}};
                end else begin
                    state_s     = CLEAR;
                    sweep_idx_s = sweep_idx_r + IDX_W'(1);
                end
            end
            RUN: begin
                if (flush_bp_i) begin
                    state_s     = CLEAR;
                    sweep_idx_s = {IDX_W{1'b0}};
                end else begin
                    state_s     = RUN;
                    sweep_idx_s = sweep_idx_r;
                end
            end
            default: begin
                state_s     = CLEAR;
                sweep_idx_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // FSM state and sweep index registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= CLEAR;
            sweep_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_s;
            sweep_idx_r <= sweep_idx_s;
        end
    end

    // Queue pointers and fill level; reset discards every queued update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   fill_r <= fill_r + CNT_W'(1);
                2'b01:   fill_r <= fill_r - CNT_W'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // Saturating count of updates lost to a full queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_r <= 8'h00;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end
    end

    // Counter table; initialised by the sweep rather than by reset
    always_ff @(posedge clk_i) begin
        if (tbl_we_s) begin
            table_r[tbl_widx_s] <= tbl_wdata_s;
        end
    end

    // Lookup of the fetch PC, optionally forwarding a same-cycle write
    always_comb begin
        lkp_idx_s = vpc_i[IDX_W:1];
        lkp_ctr_s = table_r[lkp_idx_s];
`ifdef RESOLVE_BHT_BYPASS_EN
        if (tbl_we_s && (tbl_widx_s == lkp_idx_s)) begin
            lkp_ctr_s = tbl_wdata_s;
        end else begin
            lkp_ctr_s = table_r[lkp_idx_s];
        end
`endif
    end

    assign bht_valid_o = (state_r == RUN);
    assign bht_taken_o = (state_r == RUN) && lkp_ctr_s[1];
    assign busy_o      = (state_r == CLEAR);
    assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_resolve_bht.sv
// -----------------------------------------------------------------------------
// tb_resolve_bht -- self-checking bench for resolve_bht (NR_ENTRIES=64,
// FIFO_DEPTH=4). A vector table of resolves with hand-derived expected
// predictions runs through a scoreboard queue; hand-written sequences cover
// the sweep, flush, overflow, same-cycle forwarding and reset corners.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_resolve_bht;

    logic                    clk;
    logic                    rst_ni;
    logic                    flush_bp;
    ariane_pkg::bp_resolve_t res;
    logic [riscv::VLEN-1:0]  vpc;
    logic                    bht_valid;
    logic                    bht_taken;
    logic                    busy;
    logic [7:0]              drop_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef RESOLVE_BHT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    resolve_bht #(.NR_ENTRIES(64), .FIFO_DEPTH(4)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_bp_i        (flush_bp),
        .resolved_branch_i (res),
        .vpc_i             (vpc),
        .bht_valid_o       (bht_valid),
        .bht_taken_o       (bht_taken),
        .busy_o            (busy),
        .drop_cnt_o        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               valid;
        ariane_pkg::cf_t    cf;
        logic [63:0]        pc;
        logic               taken;
        logic               exp;   // prediction for pc once this update lands
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic        exp;
        int          due;
    } sb_t;

    vec_t vecs[16];
    sb_t  sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to a point well away from the rising edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_res(input logic v, input ariane_pkg::cf_t cf,
                             input logic [63:0] pc, input logic tk);
        res.valid    = v;
        res.cf_type  = cf;
        res.pc       = pc;
        res.is_taken = tk;
    endtask

    function automatic logic [63:0] pc_of(input int idx);
        return 64'h0000_0000_8000_0000 + 64'(idx * 2);
    endfunction

    function automatic vec_t mkv(input logic v, input ariane_pkg::cf_t cf,
                                 input logic [63:0] pc, input logic tk, input logic e);
        vec_t r;
        r.valid = v; r.cf = cf; r.pc = pc; r.taken = tk; r.exp = e;
        return r;
    endfunction

    // Counts cycles with busy high, bounded so a stuck sweep cannot hang
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    logic [63:0] idle_pcs[5];
    logic        exp45[6];

    initial begin
        int n;
        sb_t e;

        // Resolve stream: counters start at 01 after the sweep
        vecs[0]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b1, 1'b1); // idx8 10
        vecs[1]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b1, 1'b1); // 11
        vecs[2]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b1, 1'b1); // 11 sat
        vecs[3]  = mkv(1'b1, ariane_pkg::JumpR,  64'h8000_0018, 1'b1, 1'b0); // ignored
        vecs[4]  = mkv(1'b1, ariane_pkg::Return, 64'h8000_0018, 1'b1, 1'b0); // ignored
        vecs[5]  = mkv(1'b0, ariane_pkg::Branch, 64'h8000_0018, 1'b1, 1'b0); // not valid
        vecs[6]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b0, 1'b1); // 10
        vecs[7]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b0, 1'b0); // 01
        vecs[8]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b0, 1'b0); // 00
        vecs[9]  = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b0, 1'b0); // 00 sat
        vecs[10] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b1, 1'b0); // 01
        vecs[11] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0010, 1'b1, 1'b1); // 10
        vecs[12] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_007E, 1'b1, 1'b1); // idx63 10
        vecs[13] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0080, 1'b0, 1'b0); // idx0 00
        vecs[14] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0002, 1'b1, 1'b1); // idx1 10
        vecs[15] = mkv(1'b1, ariane_pkg::Branch, 64'h8000_0080, 1'b1, 1'b0); // idx0 01

        idle_pcs[0] = 64'h8000_0000;
        idle_pcs[1] = 64'h8000_0010;
        idle_pcs[2] = 64'h8000_007E;
        idle_pcs[3] = 64'h8000_1234;
        idle_pcs[4] = 64'hFFFF_FFFF_FFFF_FFFE;

        res      = '0;
        flush_bp = 1'b0;
        vpc      = 64'h8000_0010;
        rst_ni   = 1'b0;

        // ---- reset state
        tick();
        chk("rst_busy",  64'(busy),      64'd1);
        chk("rst_valid", 64'(bht_valid), 64'd0);
        chk("rst_taken", 64'(bht_taken), 64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);
        rst_ni = 1'b1;

        // ---- post-reset sweep length and all-not-taken table
        count_busy(n);
        chk("sweep_len", 64'(n), 64'd64);
        for (int i = 0; i < 5; i++) begin
            vpc = idle_pcs[i];
            #1;
            chk("idle_valid", 64'(bht_valid), 64'd1);
            chk("idle_taken", 64'(bht_taken), 64'd0);
        end

        // ---- vector table through the scoreboard, one resolve every other cycle
        for (int cyc = 0; cyc < 2 * 16 + 2; cyc++) begin
            tick();
            if ((cyc % 2 == 0) && (cyc / 2 < 16)) begin
                drive_res(vecs[cyc/2].valid, vecs[cyc/2].cf, vecs[cyc/2].pc, vecs[cyc/2].taken);
                e.pc  = vecs[cyc/2].pc;
                e.exp = vecs[cyc/2].exp;
                e.due = cyc + 2;
                sb.push_back(e);
            end else begin
                res.valid = 1'b0;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                vpc = sb[0].pc;
                #1;
                chk("vec_taken", 64'(bht_taken), 64'(sb[0].exp));
                void'(sb.pop_front());
            end
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);

        // ---- same-cycle write/lookup on index 5 (counter 01, taken update)
        tick();
        drive_res(1'b1, ariane_pkg::Branch, pc_of(5), 1'b1);
        vpc = pc_of(5);
        tick();
        res.valid = 1'b0;
        #1;
        chk("bypass_same", 64'(bht_taken), 64'(BYP));
        tick();
        chk("bypass_after", 64'(bht_taken), 64'd1);

        // ---- update and flush together: entry stays queued across the sweep
        drive_res(1'b1, ariane_pkg::Branch, pc_of(20), 1'b1);
        tick();
        res.valid = 1'b0;
        flush_bp  = 1'b1;
        tick();
        flush_bp  = 1'b0;
        vpc = pc_of(8);
        #1;
        chk("flush_busy",  64'(busy),      64'd1);
        chk("flush_valid", 64'(bht_valid), 64'd0);
        chk("flush_taken", 64'(bht_taken), 64'd0);
        // ---- flush at sweep index 30 restarts the sweep
        for (int i = 0; i < 30; i++) tick();
        chk("idx30_busy", 64'(busy), 64'd1);
        flush_bp = 1'b1;
        tick();
        flush_bp = 1'b0;
        count_busy(n);
        chk("restart_len", 64'(n), 64'd64);
        tick();
        vpc = pc_of(20);
        #1;
        chk("queued_survives", 64'(bht_taken), 64'd1);
        vpc = pc_of(8);
        #1;
        chk("sweep_cleared", 64'(bht_taken), 64'd0);

        // ---- five pushes during CLEAR: one dropped, four applied after sweep
        flush_bp = 1'b1;
        tick();
        flush_bp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_res(1'b1, ariane_pkg::Branch, pc_of(40 + k), 1'b1);
            tick();
        end
        res.valid = 1'b0;
        chk("overflow_drop", 64'(drop_cnt), 64'd1);
        count_busy(n);
        chk("overflow_sweep_len", 64'(n), 64'd59);
        // queue is full and pops this cycle: the push must not be dropped
        drive_res(1'b1, ariane_pkg::Branch, pc_of(45), 1'b1);
        tick();
        res.valid = 1'b0;
        chk("full_pushpop_drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        exp45[0] = 1'b1; exp45[1] = 1'b1; exp45[2] = 1'b1;
        exp45[3] = 1'b1; exp45[4] = 1'b0; exp45[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vpc = pc_of(40 + k);
            #1;
            chk("overflow_applied", 64'(bht_taken), 64'(exp45[k]));
        end

        // ---- drop counter saturation under a held flush
        flush_bp = 1'b1;
        drive_res(1'b1, ariane_pkg::Branch, pc_of(50), 1'b1);
        for (int i = 0; i < 300; i++) tick();
        flush_bp  = 1'b0;
        res.valid = 1'b0;
        chk("drop_sat", 64'(drop_cnt), 64'hFF);
        chk("drop_sat_busy", 64'(busy), 64'd1);

        // ---- reset mid-sweep with queued updates
        for (int i = 0; i < 10; i++) tick();
        vpc    = pc_of(45);
        rst_ni = 1'b0;
        #1;
        chk("midrst_drop",  64'(drop_cnt),  64'd0);
        chk("midrst_busy",  64'(busy),      64'd1);
        chk("midrst_valid", 64'(bht_valid), 64'd0);
        chk("midrst_taken", 64'(bht_taken), 64'd0);
        tick();
        rst_ni = 1'b1;
        count_busy(n);
        chk("midrst_sweep_len", 64'(n), 64'd64);
        for (int i = 0; i < 6; i++) tick();
        vpc = pc_of(50);
        #1;
        chk("midrst_discard", 64'(bht_taken), 64'd0);
        vpc = pc_of(45);
        #1;
        chk("midrst_cleared", 64'(bht_taken), 64'd0);
        chk("midrst_drop_after", 64'(drop_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/resolve_bht.md
RESOLVE_BHT -- requirements
Module: resolve_bht

Interface
REQ-001 NR_ENTRIES, 64, number of 2-bit counters; power of two, at least 4.
REQ-002 FIFO_DEPTH, 4, resolve-update queue depth; power of two, at least 2.
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 flush_bp_i  input  1  request to clear all counters.
REQ-006 resolved_branch_i  input  ariane_pkg::bp_resolve_t  resolution from branch unit; uses valid, pc, is_taken, cf_type.
REQ-007 vpc_i  input  riscv::VLEN  fetch PC to predict.
REQ-008 bht_valid_o  output  1  prediction valid.
REQ-009 bht_taken_o  output  1  predicted taken.
REQ-010 busy_o  output  1  clear sweep in progress.
REQ-011 drop_cnt_o  output  8  count of updates lost to a full FIFO.

Function
REQ-012 Index SHALL be pc[$clog2(NR_ENTRIES):1], for both update and lookup.
REQ-013 A resolve SHALL be accepted only when valid=1 and cf_type==ariane_pkg::Branch; all other resolves are ignored.
REQ-014 An accepted resolve SHALL push {index, is_taken} into the FIFO in the same cycle.
REQ-015 FSM states SHALL be CLEAR and RUN.
REQ-016 In CLEAR, one counter per cycle SHALL be written to 2'b01 (weakly not-taken), in ascending index order starting from 0.
REQ-017 After index NR_ENTRIES-1 is written, the FSM SHALL move to RUN on the next edge.
REQ-018 In RUN with flush_bp_i=1, the FSM SHALL enter CLEAR and restart the sweep at index 0 next cycle.
REQ-019 A flush asserted during CLEAR SHALL restart the sweep at index 0.
REQ-020 In RUN with the FIFO non-empty, the head SHALL pop and its counter SHALL update: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00. Rate is one update per cycle.
REQ-021 In CLEAR the FIFO SHALL NOT pop; pushes SHALL continue; FIFO contents survive flush.
REQ-022 Push with the FIFO full and no pop that cycle SHALL drop the update and increment drop_cnt_o, saturating at 8'hFF.
REQ-023 Push and pop in the same cycle with the FIFO full SHALL succeed with no drop.
REQ-024 A push to an empty FIFO in RUN SHALL be applied to the table on the next edge at the earliest, giving two cycles from resolve to a visible counter change.
REQ-025 bht_valid_o SHALL be 1 only in RUN.
REQ-026 bht_taken_o SHALL equal bit[1] of the indexed counter, combinationally from vpc_i.
REQ-027 Outside RUN, bht_valid_o and bht_taken_o SHALL be 0.
REQ-028 busy_o SHALL be 1 exactly when the FSM is in CLEAR.
REQ-029 Update and flush in the same cycle: flush SHALL win the table port, the pop is withheld, and the entry remains queued.

Reset
REQ-030 Asserting rst_ni SHALL immediately force state=CLEAR, sweep index=0, FIFO empty, drop_cnt_o=0, busy_o=1, bht_valid_o=0 and bht_taken_o=0.
REQ-031 Counter contents SHALL NOT be reset directly; they are initialised by the post-reset sweep.
REQ-032 Reset asserted mid-sweep or mid-update SHALL discard all queued updates.

Configuration
REQ-033 With RESOLVE_BHT_BYPASS_EN defined, a lookup whose index equals the index being written that cycle SHALL return the post-update counter bit[1].
REQ-034 Without RESOLVE_BHT_BYPASS_EN, the lookup SHALL return the stored pre-update value.
REQ-035 The macro SHALL NOT change FIFO, FSM or drop behaviour.

Verification
REQ-036 Reset release, NR_ENTRIES=64 -> busy_o=1 for 64 cycles, then bht_valid_o=1 and bht_taken_o=0 for any vpc_i.
REQ-037 Three taken resolves at pc 0x80000010, one per cycle -> counter index 8 goes 01->10->11->11 (saturated); bht_taken_o=1 for vpc_i 0x80000010.
REQ-038 Five back-to-back accepted resolves issued in CLEAR with FIFO_DEPTH=4 -> drop_cnt_o=1; the four queued updates are applied after the sweep ends.
REQ-039 flush_bp_i pulsed at sweep index 30 -> sweep restarts at 0; busy_o held for 64 further cycles.
REQ-040 Resolve with cf_type=JumpR or Return, valid=1 -> no push; counters unchanged.
REQ-041 Taken update to index 5 with vpc_i indexing 5 in the same cycle, counter 01 -> bht_taken_o=1 with RESOLVE_BHT_BYPASS_EN, 0 without.
